// File: rtl/mod8_pkg.sv
// Shared definitions for the mod-8 counter and its downstream sequence checker.
package mod8_pkg;

  localparam int MOD8_W = 3;
  localparam logic [MOD8_W-1:0] MOD8_MAX = 3'd7;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    LOCK = 2'd1,
    SLIP = 2'd2
  } chk_state_t;

  // Modular successor of a counter value (7 wraps to 0).
  function automatic logic [MOD8_W-1:0] mod8_inc(input logic [MOD8_W-1:0] v);
    logic [MOD8_W-1:0] r;
    if (v == MOD8_MAX) begin
      r = 3'd0;
    end else begin
      r = v + 3'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mod8_seq_checker_if.sv
// Sample/statistics bundle between a mod-8 count producer and the sequence checker.
interface mod8_seq_checker_if #(
  parameter int WRAP_W = 8,
  parameter int ERR_W  = 4
) ();
  import mod8_pkg::*;

  logic              cnt_valid;
  logic [MOD8_W-1:0] count;
  logic              clr;
  logic              locked;
  logic [MOD8_W-1:0] expected;
  logic              wrap_pulse;
  logic              resync_pulse;
  logic              err_pulse;
  logic              err_sticky;
  logic [WRAP_W-1:0] wrap_count;
  logic [ERR_W-1:0]  err_count;

  modport master (
    output cnt_valid, count, clr,
    input  locked, expected, wrap_pulse, resync_pulse, err_pulse,
    input  err_sticky, wrap_count, err_count
  );

  modport slave (
    input  cnt_valid, count, clr,
    output locked, expected, wrap_pulse, resync_pulse, err_pulse,
    output err_sticky, wrap_count, err_count
  );

endinterface

// File: rtl/sat_counter.sv
// Event counter with synchronous clear; either saturates at all-ones or rolls over.
module sat_counter #(
  parameter int W   = 4,
  parameter bit SAT = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_r;

  // Clear wins over increment; saturating variant holds at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= {W{1'b0}};
    end else if (clr) begin
      count_r <= {W{1'b0}};
    end else if (inc) begin
      if (SAT && (count_r == {W{1'b1}})) begin
        count_r <= count_r;
      end else begin
        count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
      end
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/mod8_seq_checker.sv
// Checks that qualified mod-8 counter samples advance by +1, tracking wraps,
// upstream resets (unexpected 0 while locked) and discontinuities.
module mod8_seq_checker
  import mod8_pkg::*;
#(
  parameter int WRAP_W = 8,
  parameter int ERR_W  = 4
) (
  input logic              clk,
  input logic              rst,
  mod8_seq_checker_if.slave bus
);

  chk_state_t        state_r;
  chk_state_t        state_nxt_s;
  logic [MOD8_W-1:0] expected_r;
  logic [MOD8_W-1:0] expected_nxt_s;
  logic              locked_r;
  logic              wrap_pulse_r;
  logic              resync_pulse_r;
  logic              err_pulse_r;
  logic              err_sticky_r;
  logic              wrap_s;
  logic              resync_s;
  logic              err_s;
  logic              hit_s;
  logic              zero_s;
  logic [WRAP_W-1:0] wrap_count_s;
  logic [ERR_W-1:0]  err_count_s;

  assign hit_s  = (bus.count == expected_r);
  assign zero_s = (bus.count == 3'd0);

  // Next-state and event decode for one valid sample; idle cycles hold everything.
  always_comb begin
    state_nxt_s    = state_r;
    expected_nxt_s = expected_r;
    wrap_s         = 1'b0;
    resync_s       = 1'b0;
    err_s          = 1'b0;
    if (bus.cnt_valid) begin
      case (state_r)
        HUNT: begin
          expected_nxt_s = mod8_inc(bus.count);
          state_nxt_s    = LOCK;
        end
        LOCK: begin
          if (hit_s) begin
            expected_nxt_s = mod8_inc(bus.count);
            if (zero_s) begin
              wrap_s = 1'b1;
            end else begin
              wrap_s = 1'b0;
            end
          end else if (zero_s) begin
            // Counter restarted upstream: treat as a legal resync.
            resync_s       = 1'b1;
            expected_nxt_s = 3'd1;
          end else begin
            err_s          = 1'b1;
            expected_nxt_s = mod8_inc(bus.count);
            state_nxt_s    = SLIP;
          end
        end
        SLIP: begin
          // A zero here is not trusted as a resync; only a matching value relocks.
          expected_nxt_s = mod8_inc(bus.count);
          if (hit_s) begin
            state_nxt_s = LOCK;
          end else begin
            err_s       = 1'b1;
            state_nxt_s = SLIP;
          end
        end
        default: begin
          expected_nxt_s = 3'd0;
          state_nxt_s    = HUNT;
        end
      endcase
    end else begin
      state_nxt_s    = state_r;
      expected_nxt_s = expected_r;
    end
  end

  // FSM state, expected value and registered status/pulse outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r        <= HUNT;
      expected_r     <= 3'd0;
      locked_r       <= 1'b0;
      wrap_pulse_r   <= 1'b0;
      resync_pulse_r <= 1'b0;
      err_pulse_r    <= 1'b0;
      err_sticky_r   <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      expected_r     <= expected_nxt_s;
      locked_r       <= (state_nxt_s == LOCK);
      wrap_pulse_r   <= wrap_s;
      resync_pulse_r <= resync_s;
      err_pulse_r    <= err_s;
      if (bus.clr) begin
        err_sticky_r <= 1'b0;
      end else if (err_s) begin
        err_sticky_r <= 1'b1;
      end else begin
        err_sticky_r <= err_sticky_r;
      end
    end
  end

  sat_counter #(
    .W  (ERR_W),
    .SAT(1'b1)
  ) u_err_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (bus.clr),
    .inc  (err_s),
    .count(err_count_s)
  );

  sat_counter #(
    .W  (WRAP_W),
    .SAT(1'b0)
  ) u_wrap_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (bus.clr),
    .inc  (wrap_s),
    .count(wrap_count_s)
  );

  assign bus.locked       = locked_r;
  assign bus.expected     = expected_r;
  assign bus.wrap_pulse   = wrap_pulse_r;
  assign bus.resync_pulse = resync_pulse_r;
  assign bus.err_pulse    = err_pulse_r;
  assign bus.err_sticky   = err_sticky_r;
  assign bus.wrap_count   = wrap_count_s;
  assign bus.err_count    = err_count_s;

endmodule

// File: tb/tb_mod8_seq_checker.sv
// Directed, table-driven bench for mod8_seq_checker with hand-computed expectations.
module tb_mod8_seq_checker;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mod8_seq_checker_if #(.WRAP_W(8), .ERR_W(4)) bus ();

  mod8_seq_checker #(.WRAP_W(8), .ERR_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [2:0] c;
    logic       cl;
    logic       lk;
    logic [2:0] ex;
    logic       wp;
    logic       rp;
    logic       ep;
    logic       st;
    logic [7:0] wc;
    logic [3:0] ec;
  } vec_t;

  vec_t tbl [24];

  function automatic vec_t mk(input logic v, input logic [2:0] c, input logic cl,
                              input logic lk, input logic [2:0] ex, input logic wp,
                              input logic rp, input logic ep, input logic st,
                              input logic [7:0] wc, input logic [3:0] ec);
    vec_t r;
    r.v = v; r.c = c; r.cl = cl; r.lk = lk; r.ex = ex; r.wp = wp;
    r.rp = rp; r.ep = ep; r.st = st; r.wc = wc; r.ec = ec;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic chk_outs(input string tag, input logic lk, input logic [2:0] ex,
                          input logic wp, input logic rp, input logic ep, input logic st,
                          input logic [7:0] wc, input logic [3:0] ec);
    chk({tag, ".locked"},       {31'd0, bus.locked},       {31'd0, lk});
    chk({tag, ".expected"},     {29'd0, bus.expected},     {29'd0, ex});
    chk({tag, ".wrap_pulse"},   {31'd0, bus.wrap_pulse},   {31'd0, wp});
    chk({tag, ".resync_pulse"}, {31'd0, bus.resync_pulse}, {31'd0, rp});
    chk({tag, ".err_pulse"},    {31'd0, bus.err_pulse},    {31'd0, ep});
    chk({tag, ".err_sticky"},   {31'd0, bus.err_sticky},   {31'd0, st});
    chk({tag, ".wrap_count"},   {24'd0, bus.wrap_count},   {24'd0, wc});
    chk({tag, ".err_count"},    {28'd0, bus.err_count},    {28'd0, ec});
  endtask

  // Drive one cycle of inputs, let the edge happen, settle just after it.
  task automatic step(input logic v, input logic [2:0] c, input logic cl);
    bus.cnt_valid = v;
    bus.count     = c;
    bus.clr       = cl;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.cnt_valid = 1'b0;
    bus.count     = 3'd0;
    bus.clr       = 1'b0;
    #10;
    rst = 1'b1;
  endtask

  int         n_wrap;
  int         n_resync;
  int         n_err;
  logic [2:0] ctr;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.cnt_valid = 1'b0;
    bus.count     = 3'd0;
    bus.clr       = 1'b0;

    // v    c     clr   lk    ex    wp    rp    ep    st    wc     ec
    tbl[0]  = mk(1'b1, 3'd0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0);
    tbl[1]  = mk(1'b1, 3'd1, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0);
    tbl[2]  = mk(1'b1, 3'd2, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0);
    tbl[3]  = mk(1'b1, 3'd3, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0);
    tbl[4]  = mk(1'b1, 3'd4, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0);
    tbl[5]  = mk(1'b1, 3'd5, 1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0);
    tbl[6]  = mk(1'b1, 3'd6, 1'b0, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0);
    tbl[7]  = mk(1'b1, 3'd7, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0);
    tbl[8]  = mk(1'b1, 3'd0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 4'd0);
    tbl[9]  = mk(1'b1, 3'd1, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 4'd0);
    tbl[10] = mk(1'b0, 3'd5, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 4'd0);
    tbl[11] = mk(1'b1, 3'd2, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 4'd0);
    tbl[12] = mk(1'b1, 3'd3, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 4'd0);
    tbl[13] = mk(1'b1, 3'd4, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 4'd0);
    tbl[14] = mk(1'b1, 3'd3, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1, 4'd1);
    tbl[15] = mk(1'b1, 3'd4, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 4'd1);
    tbl[16] = mk(1'b1, 3'd2, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1, 4'd2);
    tbl[17] = mk(1'b1, 3'd0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1, 4'd3);
    tbl[18] = mk(1'b1, 3'd1, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 4'd3);
    tbl[19] = mk(1'b1, 3'd0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1, 4'd3);
    tbl[20] = mk(1'b1, 3'd7, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1, 4'd4);
    tbl[21] = mk(1'b1, 3'd0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 4'd4);
    tbl[22] = mk(1'b1, 3'd1, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 4'd4);
    tbl[23] = mk(1'b0, 3'd0, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0);

    // Reset state while rst is held low.
    #12;
    chk_outs("reset", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0);
    rst = 1'b1;

    // Main table: lock, wrap, hold, LOCK error, SLIP zero, resync, SLIP 7->0, clr.
    for (int i = 0; i < 24; i++) begin
      step(tbl[i].v, tbl[i].c, tbl[i].cl);
      chk_outs($sformatf("row%0d", i), tbl[i].lk, tbl[i].ex, tbl[i].wp, tbl[i].rp,
               tbl[i].ep, tbl[i].st, tbl[i].wc, tbl[i].ec);
    end

    // 20 consecutive errors: err_count saturates at 15.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 3'd5, 1'b0);
      chk_outs($sformatf("sat%0d", i), 1'b0, 3'd6, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0,
               (i >= 14) ? 4'd15 : 4'(i + 1));
    end
    // clr alongside a further error: pulse fires, statistics stay cleared.
    step(1'b1, 3'd5, 1'b1);
    chk_outs("clr_err", 1'b0, 3'd6, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 4'd0);

    // Model of the upstream counter: reset, run 8 cycles, reset, run 4 cycles.
    do_reset();
    n_wrap = 0; n_resync = 0; n_err = 0;
    ctr = 3'd0;
    for (int i = 0; i < 14; i++) begin
      if (i == 0 || i == 9) begin
        ctr = 3'd0;
      end else begin
        ctr = ctr + 3'd1;
      end
      step(1'b1, ctr, 1'b0);
      n_wrap   += int'(bus.wrap_pulse);
      n_resync += int'(bus.resync_pulse);
      n_err    += int'(bus.err_pulse);
    end
    chk("ctr.resyncs", n_resync, 1);
    chk("ctr.wraps", n_wrap, 1);
    chk("ctr.errs", n_err, 0);
    chk_outs("ctr.end", 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 4'd0);

    // Asynchronous reset mid-cycle while locked at count 5.
    step(1'b1, 3'd5, 1'b0);
    chk_outs("pre_async", 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 4'd0);
    #2;
    rst = 1'b0;
    #1;
    chk_outs("async_rst", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0);
    #2;
    rst = 1'b1;
    step(1'b1, 3'd2, 1'b0);
    chk_outs("relock", 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
